// File: rtl/sparse_dense_mult_engine.sv
// sparse_dense_mult_engine: un-reduced GF(2) sparse x dense product streamed into the result RAM.
// Define DUMMY_INSERT_EN for constant-time operation (MAX_WEIGHT iterations, extra ones are dummies).
module sparse_dense_mult_engine #(
  parameter int N          = 17669,
  parameter int WEIGHT     = 66,
  parameter int MAX_WEIGHT = 75,
  parameter int RAMWIDTH   = 32,
  parameter int NW         = (N + RAMWIDTH - 1) / RAMWIDTH,
  parameter int RES_WORDS  = 2 * NW,
  parameter int LOGW       = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start_i,
  output logic                                            busy_o,
  output logic                                            done_o,
  output logic                                            err_o,
  output logic [(MAX_WEIGHT > 1 ? $clog2(MAX_WEIGHT) : 1)-1:0] pos_addr_o,
  input  logic [LOGW-1:0]                                 pos_data_i,
  output logic [(NW > 1 ? $clog2(NW) : 1)-1:0]            dense_addr_o,
  input  logic [RAMWIDTH-1:0]                             dense_data_i,
  output logic [$clog2(RES_WORDS)-1:0]                    res_rd_addr_o,
  input  logic [RAMWIDTH-1:0]                             res_rd_data_i,
  output logic [$clog2(RES_WORDS)-1:0]                    res_wr_addr_o,
  output logic [RAMWIDTH-1:0]                             res_wr_data_o,
  output logic                                            res_wr_en_o
);
  localparam int PAW = MAX_WEIGHT > 1 ? $clog2(MAX_WEIGHT) : 1;
  localparam int DAW = NW > 1 ? $clog2(NW) : 1;
  localparam int AW  = $clog2(RES_WORDS);
  localparam int IW  = $clog2(MAX_WEIGHT + 1);
  localparam int SW  = $clog2(RAMWIDTH);
`ifdef DUMMY_INSERT_EN
  localparam int ITERS = MAX_WEIGHT;
`else
  localparam int ITERS = WEIGHT;
`endif
  localparam int REM = N % RAMWIDTH;
  localparam logic [RAMWIDTH-1:0] TAIL_MASK = REM == 0 ? {RAMWIDTH{1'b1}} : RAMWIDTH'((64'd1 << REM) - 64'd1);
  localparam logic [AW-1:0] CLR_END = AW'(RES_WORDS - 1);
  localparam logic [AW-1:0] K_END   = AW'(NW);
  localparam logic [IW-1:0] IT_END  = IW'(ITERS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH0, FETCH1, STREAM, LAST, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0]         cnt, wb_q;
  logic [SW-1:0]         s_q;
  logic [IW-1:0]         iter;
  logic                  dummy_q, err_q, pos_bad, dummy_n, wr_acc;
  logic [PAW-1:0]        idx;
  logic [RAMWIDTH-1:0]   dprev_q, d_cur;
  logic [2*RAMWIDTH-1:0] win;

  assign pos_bad = pos_data_i >= LOGW'(N);
`ifdef DUMMY_INSERT_EN
  localparam logic [IW-1:0] WT = IW'(WEIGHT);
  assign idx     = PAW'(iter >= WT ? iter - WT : iter);
  assign dummy_n = pos_bad || iter >= WT;
`else
  assign idx     = PAW'(iter);
  assign dummy_n = pos_bad;
`endif
  assign err_o = err_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_i ? CLEAR : IDLE;
      CLEAR:   state_n = cnt == CLR_END ? FETCH0 : CLEAR;
      FETCH0:  state_n = FETCH1;
      FETCH1:  state_n = STREAM;
      STREAM:  state_n = cnt == K_END ? LAST : STREAM;
      LAST:    state_n = iter == IT_END ? DONE : FETCH0;
      default: state_n = IDLE;
    endcase
  end

  // invalid positions become shift-0 dummies so addresses stay in range
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      wb_q    <= '0;
      s_q     <= '0;
      iter    <= '0;
      dummy_q <= 1'b0;
      err_q   <= 1'b0;
      dprev_q <= '0;
    end else
      case (state)
        IDLE: if (start_i) begin
          err_q <= 1'b0;
          iter  <= '0;
          cnt   <= '0;
        end
        CLEAR:  cnt <= cnt + 1'b1;
        FETCH0: dprev_q <= '0;
        FETCH1: begin
          wb_q    <= AW'(pos_bad ? '0 : pos_data_i >> SW);
          s_q     <= pos_bad ? '0 : pos_data_i[SW-1:0];
          dummy_q <= dummy_n;
          err_q   <= err_q | pos_bad;
          cnt     <= '0;
        end
        STREAM: begin
          cnt <= cnt + 1'b1;
          if (cnt != '0) dprev_q <= d_cur;
        end
        LAST:    iter <= iter + 1'b1;
        default: ;
      endcase

  // cnt is one ahead of the word being written: the write retires issue cnt-1
  always_comb begin
    wr_acc        = state == LAST || (state == STREAM && cnt != '0);
    d_cur         = state == LAST ? '0 : cnt == K_END ? dense_data_i & TAIL_MASK : dense_data_i;
    win           = {d_cur, dprev_q} << s_q;
    busy_o        = state != IDLE && state != DONE;
    done_o        = state == DONE;
    pos_addr_o    = state == FETCH0 ? idx : '0;
    dense_addr_o  = state == STREAM && cnt != K_END ? DAW'(cnt) : '0;
    res_rd_addr_o = state == STREAM ? AW'(wb_q + cnt) : '0;
    res_wr_en_o   = state == CLEAR || wr_acc;
    res_wr_addr_o = state == CLEAR ? cnt : wr_acc ? AW'(wb_q + cnt - 1'b1) : '0;
    res_wr_data_o = wr_acc ? res_rd_data_i ^ (dummy_q ? '0 : win[2*RAMWIDTH-1:RAMWIDTH]) : '0;
  end
endmodule

// File: tb/tb_sparse_dense_mult_engine.sv
// tb_sparse_dense_mult_engine: randomized and directed checks against a bit-level polynomial model.
module tb_sparse_dense_mult_engine;
  localparam int N = 17669, W = 3, MW = 4, NW = 553, RW = 1106, LOGW = 16;
`ifdef DUMMY_INSERT_EN
  localparam int ITERS = MW;
`else
  localparam int ITERS = W;
`endif
  localparam int EXP_DONE = RW + ITERS * (NW + 4) + 1;
  localparam int EXP_WR   = RW + ITERS * (NW + 1);

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        busy, done, err, wr_en;
  logic [1:0]  pos_addr;
  logic [15:0] pos_data;
  logic [9:0]  dense_addr;
  logic [31:0] dense_data, rd_data, wr_data;
  logic [10:0] rd_addr, wr_addr;

  logic [15:0] pos_mem[MW];
  logic [31:0] dense_mem[NW];
  logic [31:0] res_mem[RW];
  logic [31:0] exp_mem[RW];
  bit [RW*32-1:0] acc;
  int checks = 0, failures = 0;
  int run_cyc, run_wr;
  logic err_c1, busy_c1;

  sparse_dense_mult_engine #(.N(N), .WEIGHT(W), .MAX_WEIGHT(MW), .LOGW(LOGW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .pos_addr_o(pos_addr), .pos_data_i(pos_data), .dense_addr_o(dense_addr), .dense_data_i(dense_data),
    .res_rd_addr_o(rd_addr), .res_rd_data_i(rd_data), .res_wr_addr_o(wr_addr),
    .res_wr_data_o(wr_data), .res_wr_en_o(wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pos_data   <= pos_mem[pos_addr];
    dense_data <= dense_mem[dense_addr];
    rd_data    <= res_mem[rd_addr];
    if (wr_en) res_mem[wr_addr] <= wr_data;
  end

  task automatic set_ops(input int p0, input int p1, input int p2, input bit rnd);
    pos_mem[0] = 16'(p0);
    pos_mem[1] = 16'(p1);
    pos_mem[2] = 16'(p2);
    pos_mem[3] = 16'($urandom_range(0, N - 1));
    for (int i = 0; i < NW; i++) dense_mem[i] = rnd ? $urandom : 32'h0;
    for (int i = 0; i < RW; i++) res_mem[i] = $urandom;
  endtask

  task automatic build_model();
    int p;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      p = int'(pos_mem[i]);
      if (p < N)
        for (int b = 0; b < N; b++)
          if (dense_mem[b / 32][b % 32]) acc[p + b] = ~acc[p + b];
    end
    for (int i = 0; i < RW; i++) exp_mem[i] = acc[i*32 +: 32];
  endtask

  task automatic count_bad(output int bad, output int first);
    bad = 0;
    first = -1;
    for (int i = 0; i < RW; i++)
      if (res_mem[i] !== exp_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
  endtask

  task automatic run_op(input int kick_at);
    int cyc;
    bit seen;
    build_model();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    run_wr = 0;
    seen = 0;
    err_c1 = err;
    busy_c1 = busy;
    while (!seen && cyc < EXP_DONE + 200) begin
      if (wr_en) run_wr++;
      if (done) seen = 1;
      else begin
        if (cyc == kick_at) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc++;
      end
    end
    run_cyc = seen ? cyc : -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, err, wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, err, wr_en});
    end
    checks++;
    if ({pos_addr, dense_addr, rd_addr, wr_addr} !== '0) begin
      failures++;
      $display("FAIL reset_addrs: got %h want 0", {pos_addr, dense_addr, rd_addr, wr_addr});
    end
    checks++;
    if (wr_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_wdata: got %h want 0", wr_data);
    end
  endtask

  task automatic test_unit_pos();
    int bad, first;
    set_ops(0, 5, 5, 0);
    dense_mem[0] = 32'h1;
    run_op(0);
    count_bad(bad, first);
    checks++;
    if (busy_c1 !== 1'b1) begin
      failures++;
      $display("FAIL unit_busy_c1: got %b want 1", busy_c1);
    end
    checks++;
    if (run_cyc != EXP_DONE) begin
      failures++;
      $display("FAIL unit_done_cycle: got %0d want %0d", run_cyc, EXP_DONE);
    end
    checks++;
    if (run_wr != EXP_WR) begin
      failures++;
      $display("FAIL unit_write_count: got %0d want %0d", run_wr, EXP_WR);
    end
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL unit_done_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (res_mem[0] !== 32'h1) begin
      failures++;
      $display("FAIL unit_res0: got %h want 00000001", res_mem[0]);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL unit_words: got %0d bad (first %0d) want 0", bad, first);
    end
  endtask

  task automatic test_shift37();
    int bad, first;
    set_ops(37, 9, 9, 0);
    dense_mem[0] = 32'hF000_0001;
    run_op(0);
    count_bad(bad, first);
    checks++;
    if (res_mem[1] !== 32'h20 || res_mem[2] !== 32'h1E) begin
      failures++;
      $display("FAIL shift37: got %h %h want 00000020 0000001e", res_mem[1], res_mem[2]);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL shift37_words: got %0d bad (first %0d) want 0", bad, first);
    end
  endtask

  task automatic test_tail_mask();
    int bad, first;
    set_ops(N - 1, 100, 100, 0);
    dense_mem[NW-1] = 32'hFFFF_FFFF;
    run_op(0);
    count_bad(bad, first);
    checks++;
    if (res_mem[1104] !== 32'h1F0 || res_mem[1105] !== 32'h0) begin
      failures++;
      $display("FAIL tail_mask: got %h %h want 000001f0 00000000", res_mem[1104], res_mem[1105]);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL tail_words: got %0d bad (first %0d) want 0", bad, first);
    end
  endtask

  task automatic test_cancel();
    int bad, first;
    set_ops(5, 5, $urandom_range(0, N - 1), 1);
    run_op(0);
    count_bad(bad, first);
    checks++;
    if (bad != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL cancel: got %0d bad err=%b want 0 bad err=0", bad, err);
    end
  endtask

  task automatic test_error();
    int bad, first;
    set_ops(N, 65535, $urandom_range(0, N - 1), 1);
    run_op(0);
    count_bad(bad, first);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL error_flag: got %b want 1", err);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL error_words: got %0d bad (first %0d) want 0", bad, first);
    end
    set_ops($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1);
    run_op(0);
    checks++;
    if (err_c1 !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL error_clear: got c1=%b end=%b want 0 0", err_c1, err);
    end
  endtask

  task automatic test_random();
    int bad, first;
    for (int r = 0; r < 2; r++) begin
      set_ops($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1);
      run_op(0);
      count_bad(bad, first);
      checks++;
      if (bad != 0 || run_cyc != EXP_DONE) begin
        failures++;
        $display("FAIL random%0d: got %0d bad cyc=%0d want 0 bad cyc=%0d", r, bad, run_cyc, EXP_DONE);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int bad, first;
    set_ops($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1);
    run_op(RW + 700);
    count_bad(bad, first);
    checks++;
    if (bad != 0 || run_cyc != EXP_DONE || run_wr != EXP_WR) begin
      failures++;
      $display("FAIL busy_start: got %0d bad cyc=%0d wr=%0d want 0 %0d %0d", bad, run_cyc, run_wr, EXP_DONE, EXP_WR);
    end
  endtask

  task automatic test_reset_mid();
    int bad, first;
    set_ops($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (RW + 300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, wr_en, rd_addr, wr_addr, dense_addr, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b wr_en=%b rd=%0d wr=%0d want all 0", busy, wr_en, rd_addr, wr_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_op(0);
    count_bad(bad, first);
    checks++;
    if (bad != 0 || run_cyc != EXP_DONE) begin
      failures++;
      $display("FAIL after_reset: got %0d bad cyc=%0d want 0 bad cyc=%0d", bad, run_cyc, EXP_DONE);
    end
  endtask

  initial begin
    for (int i = 0; i < MW; i++) pos_mem[i] = '0;
    for (int i = 0; i < NW; i++) dense_mem[i] = '0;
    for (int i = 0; i < RW; i++) res_mem[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    test_unit_pos();
    test_shift37();
    test_tail_mask();
    test_cancel();
    test_error();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sparse_dense_mult_engine.md
# sparse_dense_mult_engine

Downstream of the loader that fills the position RAM (sparse support, one position per entry) and the dense-operand word RAM. On `start_i`, this engine computes the un-reduced GF(2) product of the sparse and dense polynomials (sum over positions p of dense·x^p, 2N bits) into an external result RAM, one 32-bit word per cycle. The reduction mod x^N−1 is done by a later stage.

## Interface
Parameters:
- `N`, 17669: polynomial length in bits.
- `WEIGHT`, 66: real positions per operation.
- `MAX_WEIGHT`, 75: iteration count when dummy insertion is compiled in.
- `RAMWIDTH`, 32: word width.
- `NW`, ceil(N/RAMWIDTH)=553: dense words.
- `RES_WORDS`, 1106: result words; 2N bits padded to an even word count.
- `LOGW`, 16: position width.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin operation; sampled only in IDLE.
- `busy_o`  out  1  high from the cycle after start until done.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  sticky; set when a position ≥ N is read; cleared by start.
- `pos_addr_o`  out  clog2(MAX_WEIGHT)  position RAM read address.
- `pos_data_i`  in  LOGW  position data; synchronous read, 1-cycle latency.
- `dense_addr_o`  out  clog2(NW)  dense RAM read address.
- `dense_data_i`  in  32  dense data; 1-cycle latency.
- `res_rd_addr_o`  out  clog2(RES_WORDS)  result read address.
- `res_rd_data_i`  in  32  result read data; 1-cycle latency.
- `res_wr_addr_o`  out  clog2(RES_WORDS)  result write address.
- `res_wr_data_o`  out  32  result write data.
- `res_wr_en_o`  out  1  result write strobe.

## Operation
- Reset values: all outputs 0; FSM enters IDLE; iteration counter 0.
- IDLE: when `start_i`=1, clear `err_o` and go to CLEAR.
- CLEAR: write 0 to result words 0..RES_WORDS−1, one word per cycle. Then go to FETCH.
- FETCH (2 cycles): drive `pos_addr_o`=iteration index, then latch p. Compute wb = p>>5 and s = p[4:0].
  - If p ≥ N: set `err_o` and treat the iteration as dummy.
- STREAM: for k=0..NW, issue `dense_addr_o`=k and `res_rd_addr_o`=wb+k. On the following cycle, write word wb+k with res_rd ^ shifted_k.
  - shifted_k = ({d_k, d_(k−1)} << s)[63:32].
  - d_(−1)=0 and d_NW=0; the k=NW issue does not sample the dense RAM.
  - Mask d_(NW−1) to its low N mod 32 = 5 bits.
- After the last write: increment the iteration. If iterations remain, go to FETCH; else go to DONE.
- DONE: pulse `done_o`, drop `busy_o`, return to IDLE.
- Iteration count is WEIGHT, or MAX_WEIGHT with the macro defined.
- Widths: max write address = 552+553 = 1105 < RES_WORDS. Addresses never wrap.

## Timing
- Start sampled at cycle 0. `busy_o`=1 from cycle 1.
- CLEAR occupies cycles 1..RES_WORDS.
- Each iteration takes NW+4 = 557 cycles: 2 fetch, NW+1 issues, 1 final write.
- `done_o` is high in cycle RES_WORDS + iters·557 + 1. `busy_o` is 0 in that same cycle.
- Within an iteration, the read of wb+k+1 coincides with the write of wb+k. These addresses are always distinct, so there is no RAW hazard.
- Between iterations, the next read is issued ≥2 cycles after the last write.
- `start_i` while busy is ignored.
- `rst_n` low mid-operation: return to IDLE immediately with outputs 0. Result RAM contents are undefined.

## Configuration
- `DUMMY_INSERT_EN` defined: run MAX_WEIGHT iterations. Iterations ≥ WEIGHT are dummy:
  - read `pos_addr_o` = iteration−WEIGHT;
  - perform full FETCH/STREAM with identical addresses and strobes;
  - write back res_rd unchanged (XOR with 0).
  - Timing and write count are independent of WEIGHT. The result is identical to macro-undefined.
- `DUMMY_INSERT_EN` undefined: run WEIGHT iterations only; no dummy logic.

## Test plan
- WEIGHT=1, p=0, dense[0]=0x00000001, others 0 → res[0]=0x00000001, all other words 0; `done_o` at cycle 1106+557+1=1664.
- WEIGHT=1, p=37, dense[0]=0xF0000001 → res[1]=0x00000020, res[2]=0x0000001E, others 0.
- WEIGHT=1, p=17668, dense[552]=0xFFFFFFFF → res[1104]=0x000001F0 (mask applied), res[1105]=0.
- WEIGHT=2, positions {5,5}, random dense → all result words 0 (XOR cancellation); `err_o`=0.
- WEIGHT=2, MAX_WEIGHT=4, macro on → results match macro off; `res_wr_en_o` pulses = 1106+4·554; `done_o` at cycle 1106+4·557+1.
- Position 17669 → `err_o`=1 and no contribution. `start_i` pulsed while busy → ignored. `rst_n` low mid-STREAM → outputs 0, then a fresh start completes correctly.
